// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_e;

    typedef logic req_id_t;

    localparam int DEPTH_DEFAULT     = 32;
    localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake plus memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0,   req1;
    logic              lock0,  lock1;
    logic              we0,    we1;
    logic [31:0]       addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err0,   err1;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory
    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker; an active owner masks out the other requester.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    rr_ptr,
    input  logic       own_en,
    input  req_id_t    own_id,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = '0;
        if (own_en) begin
            gnt[own_id] = req[own_id];
        end else if (req == 2'b11) begin
            gnt[rr_ptr] = 1'b1;
        end else begin
            gnt = req;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin / locked-burst arbiter sharing one single-port word memory
// between two requesters, with range checking and registered completion.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int DATA_W    = 32
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [31:0]     DEPTH_W   = 32'(DEPTH);

    logic [1:0]             req, lock, we;
    logic [1:0][31:0]       addr;
    logic [1:0][DATA_W-1:0] wdata;

    assign req   = {bus.req1,   bus.req0};
    assign lock  = {bus.lock1,  bus.lock0};
    assign we    = {bus.we1,    bus.we0};
    assign addr  = {bus.addr1,  bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

    state_e                 state_q, state_d;
    req_id_t                rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic              owned, forced, own_en, any_gnt, in_rng;
    req_id_t           own_id, gid;
    logic [1:0]        pick, gnt_vec;
    logic              mem_we_c;
    logic [31:0]       mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // The owner keeps the bus only while it still requests with lock and
    // has burst budget left; otherwise fall back to plain round-robin.
    assign owned  = (state_q != IDLE);
    assign own_id = req_id_t'(state_q == OWN1);
    assign forced = owned && (burst_cnt_q == BURST_MAX);
    assign own_en = owned && req[own_id] && lock[own_id] && !forced;

    dmem_rr_pick u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .own_en (own_en),
        .own_id (own_id),
        .gnt    (pick)
    );

    assign gnt_vec = pick & {2{rst_n}};
    assign any_gnt = |gnt_vec;
    assign gid     = gnt_vec[1];
    assign in_rng  = (addr[gid] < DEPTH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = IDLE;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = '0;
        if (any_gnt) begin
            rr_ptr_d = ~gid;
            if (own_en) begin
                state_d     = state_q;
                burst_cnt_d = burst_cnt_q + BW'(1);
            end else if (lock[gid] && !(forced && gid == own_id)) begin
                // A forced-out owner re-granted only because nobody else asked
                // still gives up the lock.
                state_d     = gid ? OWN1 : OWN0;
                burst_cnt_d = BW'(1);
            end
        end
    end

    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        rvalid_d    = gnt_vec;
        err_d       = gnt_vec & {2{~in_rng}};
        rdata_d     = rdata_q;
        if (any_gnt) begin
            mem_addr_c  = addr[gid];
            mem_wdata_c = wdata[gid];
            mem_we_c    = we[gid] & in_rng;
            if (!we[gid]) rdata_d[gid] = in_rng ? bus.mem_rdata : '0;
        end
    end

    assign bus.gnt0      = gnt_vec[0];
    assign bus.gnt1      = gnt_vec[1];
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];
    assign bus.err0      = err_q[0];
    assign bus.err1      = err_q[1];
    assign bus.rdata0    = rdata_q[0];
    assign bus.rdata1    = rdata_q[1];
endmodule
